// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared codes, FSM state and micro-op type for the ALU control sequencer
package alu_ctrl_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_R   = 2'b10;
  localparam logic [1:0] OP_AND = 2'b11;
  localparam logic [3:0] F_ADD  = 4'b0000;
  localparam logic [3:0] F_SUB  = 4'b0010;
  localparam logic [3:0] F_AND  = 4'b0100;
  localparam logic [3:0] F_SLT  = 4'b1010;
  localparam logic [3:0] F_SRLV = 4'b0110;
  localparam logic [3:0] F_JMOR = 4'b0101;
  localparam logic [3:0] F_JALR = 4'b1001;
  localparam logic [2:0] G_ADD = 3'b010;
  localparam logic [2:0] G_SUB = 3'b110;
  localparam logic [2:0] G_AND = 3'b000;
  localparam logic [2:0] G_OR  = 3'b001;
  localparam logic [2:0] G_JAL = 3'b011;
  localparam logic [2:0] G_SRL = 3'b100;
  localparam logic [2:0] G_SLT = 3'b111;
  typedef enum logic [1:0] {EMPTY, STEP0, STEP1} state_t;
  typedef struct packed {
    logic [2:0] gout;
    logic       link_r;
    logic       reg_31_r;
    logic       jump_mem;
    logic       jmor_mem;
    logic       jalr;
    logic       last;
    logic       illegal;
  } uop_t;
endpackage

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational map of (aluop, funct, step) to one micro-op
//   aluop_i/funct_i: instruction fields; step_i: 0 first micro-op, 1 second; uop_o: decoded micro-op
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W      = 6,
  parameter int STRICT_FUNCT = 0
) (
  input  logic [1:0]         aluop_i,
  input  logic [FUNCT_W-1:0] funct_i,
  input  logic               step_i,
  output uop_t               uop_o
);
  logic strict_ok;
  always_comb begin
    strict_ok = 1'b1;
    // upper funct bits must read as the canonical R-type pattern (only bit 5 set)
    for (int i = 4; i < FUNCT_W; i++) if (funct_i[i] != (i == 5)) strict_ok = 1'b0;
    uop_o = '0;
    uop_o.gout = G_ADD;
    uop_o.last = 1'b1;
    case (aluop_i)
      OP_ADD: uop_o.gout = G_ADD;
      OP_SUB: uop_o.gout = G_SUB;
      OP_AND: uop_o.gout = G_AND;
      default:
        if (STRICT_FUNCT != 0 && !strict_ok) uop_o.illegal = 1'b1;
        else
          case (funct_i[3:0])
            F_ADD:  uop_o.gout = G_ADD;
            F_SUB:  uop_o.gout = G_SUB;
            F_AND:  uop_o.gout = G_AND;
            F_SLT:  uop_o.gout = G_SLT;
            F_SRLV: uop_o.gout = G_SRL;
            F_JMOR:
              if (step_i) begin
                uop_o.link_r = 1'b1;
                uop_o.reg_31_r = 1'b1;
              end else begin
                uop_o.gout = G_OR;
                uop_o.jump_mem = 1'b1;
                uop_o.jmor_mem = 1'b1;
                uop_o.last = 1'b0;
              end
            F_JALR:
              if (step_i) begin
                uop_o.link_r = 1'b1;
                uop_o.jalr = 1'b1;
              end else begin
                uop_o.gout = G_JAL;
                uop_o.jump_mem = 1'b1;
                uop_o.jalr = 1'b1;
                uop_o.last = 1'b0;
              end
            default: uop_o.illegal = 1'b1;
          endcase
    endcase
  end
endmodule

// File: rtl/alu_ctrl_seq.sv
// alu_ctrl_seq: registered ALU-control sequencer issuing one or two micro-ops per instruction
//   in_valid/in_ready/aluop/funct: instruction handshake; flush: abort in-flight sequence
//   out_valid/out_ready: micro-op handshake; gout + flag outputs: current micro-op
//   cnt_instr/cnt_complex: saturating completion counters
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int FUNCT_W      = 6,
  parameter int CTRL_W       = 3,
  parameter int STRICT_FUNCT = 0,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         aluop,
  input  logic [FUNCT_W-1:0] funct,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  gout,
  output logic               link_r,
  output logic               reg_31_r,
  output logic               jump_mem,
  output logic               jmor_mem,
  output logic               jalr,
  output logic               out_last,
  output logic               illegal,
  output logic [CNT_W-1:0]   cnt_instr,
  output logic [CNT_W-1:0]   cnt_complex
);
  state_t             state_q;
  uop_t               uop_q, dec_in, dec_st;
  logic [1:0]         aluop_q;
  logic [FUNCT_W-1:0] funct_q;
  logic [CNT_W-1:0]   cnt_instr_q, cnt_complex_q;
  logic               fire, done, accept;
  alu_ctrl_decode #(.FUNCT_W(FUNCT_W), .STRICT_FUNCT(STRICT_FUNCT)) u_dec_in (
    .aluop_i(aluop), .funct_i(funct), .step_i(1'b0), .uop_o(dec_in)
  );
  // second micro-op is decoded from the held instruction, not the live inputs
  alu_ctrl_decode #(.FUNCT_W(FUNCT_W), .STRICT_FUNCT(STRICT_FUNCT)) u_dec_st (
    .aluop_i(aluop_q), .funct_i(funct_q), .step_i(1'b1), .uop_o(dec_st)
  );
  assign out_valid = state_q != EMPTY;
  assign fire      = out_valid & out_ready;
  assign done      = fire & uop_q.last;
  assign in_ready  = ~flush & ((state_q == EMPTY) | done);
  assign accept    = in_valid & in_ready;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      uop_q <= '0;
      aluop_q <= '0;
      funct_q <= '0;
      cnt_instr_q <= '0;
      cnt_complex_q <= '0;
    end else if (flush) begin
      state_q <= EMPTY;
      uop_q <= '0;
    end else begin
      if (done && cnt_instr_q != '1) cnt_instr_q <= cnt_instr_q + CNT_W'(1);
      // only two-step instructions ever complete from STEP1
      if (done && state_q == STEP1 && cnt_complex_q != '1) cnt_complex_q <= cnt_complex_q + CNT_W'(1);
      if (accept) begin
        state_q <= STEP0;
        uop_q <= dec_in;
        aluop_q <= aluop;
        funct_q <= funct;
      end else if (fire && !uop_q.last) begin
        state_q <= STEP1;
        uop_q <= dec_st;
      end else if (fire) begin
        state_q <= EMPTY;
        uop_q <= '0;
      end
    end
  end
  assign gout        = CTRL_W'(uop_q.gout);
  assign link_r      = uop_q.link_r;
  assign reg_31_r    = uop_q.reg_31_r;
  assign jump_mem    = uop_q.jump_mem;
  assign jmor_mem    = uop_q.jmor_mem;
  assign jalr        = uop_q.jalr;
  assign out_last    = uop_q.last;
  assign illegal     = uop_q.illegal;
  assign cnt_instr   = cnt_instr_q;
  assign cnt_complex = cnt_complex_q;
endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb_alu_ctrl_seq: directed and random checks of alu_ctrl_seq against a micro-op queue model
module tb_alu_ctrl_seq;
  logic       clk = 1'b0;
  logic       reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] aluop = '0;
  logic [5:0] funct = '0;
  logic       in_ready, out_valid, link_r, reg_31_r, jump_mem, jmor_mem, jalr, out_last, illegal;
  logic [2:0] gout;
  logic [3:0] cnt_instr, cnt_complex;
  int         checks = 0, errors = 0;
  int         ci = 0, cc = 0;
  logic [9:0] q[$];
  logic [3:0] codes[9] = '{4'b0000, 4'b0010, 4'b0100, 4'b1010, 4'b0110, 4'b0101, 4'b1001, 4'b1111, 4'b0011};
  alu_ctrl_seq #(.FUNCT_W(6), .CTRL_W(3), .STRICT_FUNCT(1), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .aluop(aluop), .funct(funct), .out_valid(out_valid), .out_ready(out_ready), .gout(gout),
    .link_r(link_r), .reg_31_r(reg_31_r), .jump_mem(jump_mem), .jmor_mem(jmor_mem), .jalr(jalr),
    .out_last(out_last), .illegal(illegal), .cnt_instr(cnt_instr), .cnt_complex(cnt_complex)
  );
  always #5 clk = ~clk;
  // micro-op vector: {gout[2:0], link_r, reg_31_r, jump_mem, jmor_mem, jalr, last, illegal}
  function automatic logic [9:0] obs();
    return {gout, link_r, reg_31_r, jump_mem, jmor_mem, jalr, out_last, illegal};
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic push_instr(input logic [1:0] a, input logic [5:0] f);
    if (a == 2'b00) q.push_back({3'b010, 7'b0000010});
    else if (a == 2'b01) q.push_back({3'b110, 7'b0000010});
    else if (a == 2'b11) q.push_back({3'b000, 7'b0000010});
    else if (f[5:4] != 2'b10) q.push_back({3'b010, 7'b0000011});
    else
      case (f[3:0])
        4'b0000: q.push_back({3'b010, 7'b0000010});
        4'b0010: q.push_back({3'b110, 7'b0000010});
        4'b0100: q.push_back({3'b000, 7'b0000010});
        4'b1010: q.push_back({3'b111, 7'b0000010});
        4'b0110: q.push_back({3'b100, 7'b0000010});
        4'b0101: begin q.push_back({3'b001, 7'b0011000}); q.push_back({3'b010, 7'b1100010}); end
        4'b1001: begin q.push_back({3'b011, 7'b0010100}); q.push_back({3'b010, 7'b1000110}); end
        default: q.push_back({3'b010, 7'b0000011});
      endcase
  endtask
  task automatic cyc();
    bit v, r;
    logic [9:0] h;
    @(negedge clk);
    v = q.size() > 0;
    r = !flush && (!v || (out_ready && q[0][1]));
    chk("out_valid", out_valid, v);
    chk("in_ready", in_ready, r);
    if (v) chk("uop", obs(), q[0]);
    chk("cnt_instr", cnt_instr, ci);
    chk("cnt_complex", cnt_complex, cc);
    if (flush) q.delete();
    else begin
      if (v && out_ready) begin
        h = q.pop_front();
        if (h[1]) ci = ci < 15 ? ci + 1 : ci;
        if (h[1] && h[6]) cc = cc < 15 ? cc + 1 : cc;
      end
      if (in_valid && r) push_instr(aluop, funct);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    flush = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    q.delete();
    ci = 0;
    cc = 0;
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_uop", obs(), 0);
    chk("rst_cnt", {cnt_instr, cnt_complex}, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] a, input logic [5:0] f);
    in_valid = 1'b1;
    aluop = a;
    funct = f;
  endtask
  initial begin
    do_reset();
    out_ready = 1'b1;
    send(2'b00, 6'h20); cyc();
    send(2'b01, 6'h20); cyc();
    send(2'b11, 6'h20); cyc();
    in_valid = 1'b0; cyc(); cyc();
    chk("three_instr", cnt_instr, 3);
    send(2'b10, 6'b100101); cyc();
    in_valid = 1'b0; cyc(); cyc(); cyc();
    chk("jmor_complex", cnt_complex, 1);
    send(2'b10, 6'b101001); out_ready = 1'b0; cyc();
    in_valid = 1'b0; cyc(); cyc(); cyc();
    out_ready = 1'b1; cyc(); cyc(); cyc();
    send(2'b10, 6'b100101); cyc();
    in_valid = 1'b0; cyc();
    send(2'b10, 6'b101010); cyc();
    in_valid = 1'b0;
    @(negedge clk);
    chk("slt_no_bubble", {out_valid, obs()}, {1'b1, 3'b111, 7'b0000010});
    @(posedge clk);
    #1;
    q.delete();
    ci = ci + 1;
    cyc();
    send(2'b10, 6'b101111); cyc();
    send(2'b10, 6'b000000); cyc();
    send(2'b10, 6'b000010); cyc();
    in_valid = 1'b0; cyc(); cyc();
    send(2'b10, 6'b101001); cyc();
    send(2'b00, 6'h20); flush = 1'b1; cyc();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_idle", {out_valid, obs()}, 0);
    chk("flush_cnt", {cnt_instr, cnt_complex}, {ci[3:0], cc[3:0]});
    @(posedge clk);
    #1;
    cyc();
    send(2'b10, 6'b100101); cyc();
    in_valid = 1'b0; cyc();
    do_reset();
    out_ready = 1'b1;
    send(2'b00, 6'h20);
    repeat (20) cyc();
    in_valid = 1'b0; cyc();
    chk("cnt_instr_sat", cnt_instr, 15);
    for (int i = 0; i < 18; i++) begin
      send(2'b10, 6'b101001); cyc();
      in_valid = 1'b0; cyc(); cyc();
    end
    chk("cnt_complex_sat", cnt_complex, 15);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid = 1'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 15) == 0;
      aluop = 2'($urandom);
      funct = {($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b10, codes[$urandom_range(0, 8)]};
      cyc();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
